disp_arbiter: RTL and testbench

Round-robin arbiter that lets several producers share the single write port of the 8-slot seven-segment display unit. Producers include the register-dump, debug-counter and status blocks. Each requester presents a slot number, two 16-bit values and per-value write enables under a req/ack handshake. The arbiter serialises the requests, drives the display's slot-select, value and write-strobe inputs, and holds each write on the bus for a fixed number of cycles so the display captures it reliably.

---
 rtl/disp_arbiter_if.sv | 24 ++
 rtl/disp_arbiter.sv | 63 ++++++
 tb/tb_disp_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: requester request bundle plus the display write bus driven by disp_arbiter.
interface disp_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]    req;
    logic [3*N_REQ-1:0]  req_sel;
    logic [16*N_REQ-1:0] req_val1;
    logic [16*N_REQ-1:0] req_val2;
    logic [N_REQ-1:0]    req_we1;
    logic [N_REQ-1:0]    req_we2;
    logic [N_REQ-1:0]    ack;
    logic [2:0]          outsel;
    logic [15:0]         outval1;
    logic [15:0]         outval2;
    logic                out_we1;
    logic                out_we2;
    logic                busy;
    modport master (
        output req, req_sel, req_val1, req_val2, req_we1, req_we2,
        input  ack, outsel, outval1, outval2, out_we1, out_we2, busy
    );
    modport slave (
        input  req, req_sel, req_val1, req_val2, req_we1, req_we2,
        output ack, outsel, outval1, outval2, out_we1, out_we2, busy
    );
endinterface

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin arbiter serialising requester writes onto the display write port.
module disp_arbiter #(
    parameter int N_REQ = 4,
    parameter int HOLD  = 2
) (
    input logic           clock,
    input logic           reset,
    disp_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD) + 1;
    typedef enum logic {S_IDLE, S_HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr, win, nxt;
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v >= N_REQ ? v - N_REQ : v);
    endfunction
    // Scan downward so the candidate nearest the pointer is the last to overwrite win.
    always_comb begin
        win = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req[wrap(int'(ptr) + k)]) win = wrap(int'(ptr) + k);
    end
    assign nxt = wrap(int'(win) + 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ptr         <= '0;
            bus.ack     <= '0;
            bus.outsel  <= '0;
            bus.outval1 <= '0;
            bus.outval2 <= '0;
            bus.out_we1 <= 1'b0;
            bus.out_we2 <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.ack     <= '0;
            bus.out_we1 <= 1'b0;
            bus.out_we2 <= 1'b0;
            if (state == S_IDLE) begin
                if (|bus.req) begin
                    state       <= S_HOLD;
                    cnt         <= CW'(HOLD - 1);
                    ptr         <= nxt;
                    bus.ack     <= N_REQ'(1) << win;
                    bus.outsel  <= bus.req_sel[3*win +: 3];
                    bus.outval1 <= bus.req_val1[16*win +: 16];
                    bus.outval2 <= bus.req_val2[16*win +: 16];
                    bus.out_we1 <= bus.req_we1[win];
                    bus.out_we2 <= bus.req_we2[win];
                    bus.busy    <= 1'b1;
                end
            end else if (cnt == '0) begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed checks of grant timing, round-robin order, strobes and reset for disp_arbiter.
module tb_disp_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   n;
    always #5 clock = ~clock;
    disp_arbiter_if #(.N_REQ(4)) bus ();
    disp_arbiter #(.N_REQ(4), .HOLD(2)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string t, input logic [3:0] a, input logic [2:0] s,
                           input logic [15:0] v1, input logic [15:0] v2,
                           input logic w1, input logic w2, input logic b);
        chk({t, "_ack"}, 32'(bus.ack), 32'(a));
        chk({t, "_sel"}, 32'(bus.outsel), 32'(s));
        chk({t, "_val1"}, 32'(bus.outval1), 32'(v1));
        chk({t, "_val2"}, 32'(bus.outval2), 32'(v2));
        chk({t, "_we1"}, 32'(bus.out_we1), 32'(w1));
        chk({t, "_we2"}, 32'(bus.out_we2), 32'(w2));
        chk({t, "_busy"}, 32'(bus.busy), 32'(b));
    endtask
    task automatic set_req(input int i, input logic [2:0] sel, input logic [15:0] v1,
                           input logic [15:0] v2, input logic w1, input logic w2);
        bus.req_sel[3*i +: 3]    = sel;
        bus.req_val1[16*i +: 16] = v1;
        bus.req_val2[16*i +: 16] = v2;
        bus.req_we1[i]           = w1;
        bus.req_we2[i]           = w2;
    endtask
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.ack == '0 && cyc < 20);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        bus.req = '0; bus.req_sel = '0; bus.req_val1 = '0; bus.req_val2 = '0;
        bus.req_we1 = '0; bus.req_we2 = '0;
        tick(); tick();
        chk_all("reset", 4'b0000, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); tick();
        set_req(1, 3'd3, 16'h1234, 16'hABCD, 1'b1, 1'b1);
        bus.req = 4'b0010;
        tick();
        chk_all("single", 4'b0010, 3'd3, 16'h1234, 16'hABCD, 1'b1, 1'b1, 1'b1);
        bus.req = '0;
        tick();
        chk_all("single_h2", 4'b0000, 3'd3, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("single_idle", 4'b0000, 3'd3, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b1);
        bus.req = 4'b1111;
        tick();
        chk("sim_reset_ack", 32'(bus.ack), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            chk_all($sformatf("sim_g%0d", i), 4'(1 << i), 3'(i + 4), 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b1, 1'b1);
            chk($sformatf("sim_gap%0d", i), 32'(n), (i == 0) ? 32'd1 : 32'd3);
            bus.req[i] = 1'b0;
        end
        tick(); tick();
        set_req(2, 3'd2, 16'h0202, 16'h2020, 1'b1, 1'b1);
        bus.req = 4'b0100;
        wait_ack(n);
        chk("rr_g2", 32'(bus.ack), 32'b0100);
        set_req(0, 3'd0, 16'h0A00, 16'h0B00, 1'b1, 1'b1);
        set_req(3, 3'd7, 16'h3A33, 16'h3B33, 1'b1, 1'b1);
        bus.req = 4'b1001;
        wait_ack(n);
        chk_all("rr_first", 4'b1000, 3'd7, 16'h3A33, 16'h3B33, 1'b1, 1'b1, 1'b1);
        chk("rr_gap", 32'(n), 32'd3);
        bus.req[3] = 1'b0;
        wait_ack(n);
        chk_all("rr_second", 4'b0001, 3'd0, 16'h0A00, 16'h0B00, 1'b1, 1'b1, 1'b1);
        bus.req = '0;
        tick(); tick();
        set_req(1, 3'd5, 16'h5555, 16'hFFFF, 1'b1, 1'b0);
        bus.req = 4'b0010;
        wait_ack(n);
        chk_all("partial", 4'b0010, 3'd5, 16'h5555, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        bus.req = '0;
        tick();
        chk("partial_we1_off", 32'(bus.out_we1), 32'd0);
        tick();
        set_req(2, 3'd6, 16'h6666, 16'h7777, 1'b0, 1'b0);
        bus.req = 4'b0100;
        wait_ack(n);
        chk_all("noen", 4'b0100, 3'd6, 16'h6666, 16'h7777, 1'b0, 1'b0, 1'b1);
        bus.req = '0;
        tick(); tick();
        set_req(1, 3'd1, 16'h1111, 16'h1212, 1'b1, 1'b1);
        bus.req = 4'b0010;
        wait_ack(n);
        chk("mid_grant", 32'(bus.ack), 32'b0010);
        set_req(0, 3'd0, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0);
        set_req(2, 3'd2, 16'h2A2A, 16'h2B2B, 1'b1, 1'b1);
        bus.req = 4'b0101;
        tick();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        chk_all("mid_rst", 4'b0000, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        wait_ack(n);
        chk_all("post_rst", 4'b0001, 3'd0, 16'h0A0A, 16'h0B0B, 1'b1, 1'b0, 1'b1);
        chk("post_rst_lat", 32'(n), 32'd1);
        bus.req = '0;
        set_req(0, 3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle_ack%0d", i), 32'(bus.ack), 32'h0);
            chk($sformatf("idle_we%0d", i), 32'({bus.out_we1, bus.out_we2}), 32'h0);
        end
        chk_all("idle_end", 4'b0000, 3'd0, 16'h0A0A, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
